// File: rtl/mulx_seq.sv
// mulx_seq: radix-2 shift-add X_WIDTH x Y_WIDTH multiplier with start/ready handshake.
// Define SIGNED_MODE_EN to add the sgn input and s output (signed operation).
module mulx_seq #(
    parameter int X_WIDTH = 8,
    parameter int Y_WIDTH = 8,
    parameter int P_WIDTH = X_WIDTH + Y_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [X_WIDTH-1:0] x,
    input  logic [Y_WIDTH-1:0] y,
`ifdef SIGNED_MODE_EN
    input  logic               sgn,
    output logic               s,
`endif
    output logic               busy,
    output logic               rdy,
    output logic [P_WIDTH-1:0] p
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam int CW = $clog2(Y_WIDTH);
    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [P_WIDTH:0]   acc_q, acc_d, step;
    logic [X_WIDTH-1:0] mc_q, mc_d, xm;
    logic [Y_WIDTH-1:0] ym;
    logic [P_WIDTH-1:0] p_q, p_d, res;
    logic [X_WIDTH:0]   sum;
    logic               accept, fin;
`ifdef SIGNED_MODE_EN
    logic               neg_q, neg_d, sg_q, sg_d, s_q, s_d;
`endif
    // Signed operands run as magnitudes; the product is negated on the final step.
    always_comb begin
        accept  = start && (state_q != RUN);
        fin     = (state_q == RUN) && (cnt_q == CW'(Y_WIDTH - 1));
`ifdef SIGNED_MODE_EN
        xm      = (sgn && x[X_WIDTH-1]) ? -x : x;
        ym      = (sgn && y[Y_WIDTH-1]) ? -y : y;
        neg_d   = accept ? (sgn && (x[X_WIDTH-1] ^ y[Y_WIDTH-1])) : neg_q;
        sg_d    = accept ? sgn : sg_q;
`else
        xm      = x;
        ym      = y;
`endif
        sum     = acc_q[P_WIDTH:Y_WIDTH] + (acc_q[0] ? {1'b0, mc_q} : '0);
        step    = {sum, acc_q[Y_WIDTH-1:0]} >> 1;
`ifdef SIGNED_MODE_EN
        res     = neg_q ? -step[P_WIDTH-1:0] : step[P_WIDTH-1:0];
        s_d     = fin ? (sg_q && res[P_WIDTH-1]) : s_q;
`else
        res     = step[P_WIDTH-1:0];
`endif
        mc_d    = accept ? xm : mc_q;
        acc_d   = accept ? {{(X_WIDTH+1){1'b0}}, ym} : (state_q == RUN) ? step : acc_q;
        cnt_d   = (accept || fin) ? '0 : (state_q == RUN) ? cnt_q + CW'(1) : cnt_q;
        state_d = accept ? RUN : fin ? DONE : state_q;
        p_d     = fin ? res : p_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            mc_q    <= '0;
            p_q     <= '0;
`ifdef SIGNED_MODE_EN
            neg_q   <= 1'b0;
            sg_q    <= 1'b0;
            s_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mc_q    <= mc_d;
            p_q     <= p_d;
`ifdef SIGNED_MODE_EN
            neg_q   <= neg_d;
            sg_q    <= sg_d;
            s_q     <= s_d;
`endif
        end
    end
    assign busy = (state_q == RUN);
    assign rdy  = (state_q == DONE);
    assign p    = p_q;
`ifdef SIGNED_MODE_EN
    assign s    = s_q;
`endif
endmodule
